// File: rtl/idex_stage_reg.sv
// ============================================================================
// idex_stage_reg
// ----------------------------------------------------------------------------
// ID/EX pipeline register for the five-stage MIPS core.
//
// Captures the decoded instruction (PC, operands, register fields, immediate,
// jump target and packed control vector) on each rising edge. Operand
// forwarding from FWD_N sources (index 0 highest priority) is applied both when
// a new instruction is captured and while the stage is held by a stall, so a
// producer that retires during a stall is still seen by the held instruction.
// The write-back destination (rt, rd or the link register) is resolved at
// capture. Inserted bubbles are counted in a saturating counter.
//
// Priority on each edge: rst > flush > stall > load.
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   stall, flush        : hazard-unit controls (flush wins over stall)
//   id_valid            : decode slot holds a real instruction
//   id_pc               : instruction PC
//   id_ctrl             : packed control vector
//   id_busA, id_busB    : register-file read data for rs / rt
//   id_rs/rt/rd/shf     : register fields and shift amount
//   id_imm16, id_target : immediate and jump target
//   fwd_we/addr/data    : forwarding sources, slice i belongs to source i
//   ex_*                : registered copies of the id_* fields
//   ex_dst              : resolved write-back register
//   ex_link             : ex_pc + 8 (combinational)
//   bubble_cnt          : saturating count of inserted bubbles
// ============================================================================
module idex_stage_reg #(
    parameter int unsigned       XLEN       = 32,
    parameter int unsigned       CTRL_W     = 32,
    parameter int unsigned       FWD_N      = 2,
    parameter logic [CTRL_W-1:0] KILL_MASK  = {CTRL_W{1'b1}},
    parameter int unsigned       REGWR_BIT  = 0,
    parameter int unsigned       REGDST_BIT = 1,
    parameter int unsigned       JAL_BIT    = 2,
    parameter logic [4:0]        LINK_REG   = 5'd31,
    parameter int unsigned       CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [XLEN-1:0]       id_pc,
    input  logic [CTRL_W-1:0]     id_ctrl,
    input  logic [XLEN-1:0]       id_busA,
    input  logic [XLEN-1:0]       id_busB,
    input  logic [4:0]            id_rs,
    input  logic [4:0]            id_rt,
    input  logic [4:0]            id_rd,
    input  logic [4:0]            id_shf,
    input  logic [15:0]           id_imm16,
    input  logic [25:0]           id_target,
    input  logic [FWD_N-1:0]      fwd_we,
    input  logic [5*FWD_N-1:0]    fwd_addr,
    input  logic [XLEN*FWD_N-1:0] fwd_data,
    output logic                  ex_valid,
    output logic [XLEN-1:0]       ex_pc,
    output logic [XLEN-1:0]       ex_busA,
    output logic [XLEN-1:0]       ex_busB,
    output logic [CTRL_W-1:0]     ex_ctrl,
    output logic [4:0]            ex_rs,
    output logic [4:0]            ex_rt,
    output logic [4:0]            ex_rd,
    output logic [4:0]            ex_shf,
    output logic [15:0]           ex_imm16,
    output logic [25:0]           ex_target,
    output logic [4:0]            ex_dst,
    output logic [XLEN-1:0]       ex_link,
    output logic [CNT_W-1:0]      bubble_cnt
);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_busA;
    logic [XLEN-1:0]   r_busB;
    logic [CTRL_W-1:0] r_ctrl;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic [4:0]        r_shf;
    logic [15:0]       r_imm16;
    logic [25:0]       r_target;
    logic [4:0]        r_dst;
    logic [CNT_W-1:0]  r_bubble_cnt;

    // ------------------------------------------------------------------------
    // Forwarding: lowest-index matching source wins; register 0 never matches.
    // ------------------------------------------------------------------------
    function automatic logic [XLEN-1:0] fwd(input logic [4:0]      r,
                                            input logic [XLEN-1:0] d);
        logic [XLEN-1:0] res;
        logic            hit;
        res = d;
        hit = 1'b0;
        for (int unsigned i = 0; i < FWD_N; i++) begin
            if (!hit && fwd_we[i] && (r != 5'd0) && (fwd_addr[5*i +: 5] == r)) begin
                res = fwd_data[XLEN*i +: XLEN];
                hit = 1'b1;
            end
        end
        return res;
    endfunction

    logic [XLEN-1:0]   w_id_fwd_a;
    logic [XLEN-1:0]   w_id_fwd_b;
    logic [XLEN-1:0]   w_ex_fwd_a;
    logic [XLEN-1:0]   w_ex_fwd_b;
    logic [CTRL_W-1:0] w_id_ctrl;
    logic [4:0]        w_id_dst;

    // Capture path uses the incoming fields; stall path refreshes the held ones.
    assign w_id_fwd_a = fwd(id_rs, id_busA);
    assign w_id_fwd_b = fwd(id_rt, id_busB);
    assign w_ex_fwd_a = fwd(r_rs, r_busA);
    assign w_ex_fwd_b = fwd(r_rt, r_busB);

    // A jump-and-link always writes the link register.
    always_comb begin
        w_id_ctrl = id_ctrl;
        if (id_ctrl[JAL_BIT]) begin
            w_id_ctrl[REGWR_BIT] = 1'b1;
        end
    end

    always_comb begin
        if (id_ctrl[JAL_BIT]) begin
            w_id_dst = LINK_REG;
        end else if (id_ctrl[REGDST_BIT]) begin
            w_id_dst = id_rd;
        end else begin
            w_id_dst = id_rt;
        end
    end

    // ------------------------------------------------------------------------
    // Stage register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_busA       <= '0;
            r_busB       <= '0;
            r_ctrl       <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_shf        <= '0;
            r_imm16      <= '0;
            r_target     <= '0;
            r_dst        <= '0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            // Bubble: only validity and the killable control bits change.
            r_valid <= 1'b0;
            r_ctrl  <= r_ctrl & ~KILL_MASK;
            if (r_bubble_cnt != '1) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end else if (stall) begin
            r_busA <= w_ex_fwd_a;
            r_busB <= w_ex_fwd_b;
        end else begin
            r_valid  <= id_valid;
            r_pc     <= id_pc;
            r_busA   <= w_id_fwd_a;
            r_busB   <= w_id_fwd_b;
            r_ctrl   <= w_id_ctrl;
            r_rs     <= id_rs;
            r_rt     <= id_rt;
            r_rd     <= id_rd;
            r_shf    <= id_shf;
            r_imm16  <= id_imm16;
            r_target <= id_target;
            r_dst    <= w_id_dst;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign ex_valid   = r_valid;
    assign ex_pc      = r_pc;
    assign ex_busA    = r_busA;
    assign ex_busB    = r_busB;
    assign ex_ctrl    = r_ctrl;
    assign ex_rs      = r_rs;
    assign ex_rt      = r_rt;
    assign ex_rd      = r_rd;
    assign ex_shf     = r_shf;
    assign ex_imm16   = r_imm16;
    assign ex_target  = r_target;
    assign ex_dst     = r_dst;
    assign ex_link    = r_pc + XLEN'(8);
    assign bubble_cnt = r_bubble_cnt;

endmodule
